// File: rtl/nvme_cpl_tracker.sv
// In-order NVMe I/O completion tracker.
// Completions are recorded per action by {action_id, req_id} and are handed back to the
// consumer strictly in req_id order. The tracker also counts outstanding commands, runs
// a per-action watchdog and captures the first error.
//
// Ports:
//   axi_aclk, axi_aresetn        clock, asynchronous active-low reset
//   init_done_o                  store cleared, block operational
//   cpl_*_i                      completion strobe, admin flag, action, req_id, status, raw entry
//   issue_valid_i/action_id_i    command issued; issue_full_o flags a full action
//   pop_req_i/pop_action_id_i    consume head; pop_done_o/pop_valid_o/pop_data_o one cycle later
//   track_status_o               head entry of each action is complete
//   overflow_o                   sticky: completion landed on an already-valid slot
//   err_clear_i                  clears error capture, error count and timeouts
//   err_valid_o/err_data_o       first-error capture
//   err_count_o                  saturating count of completions with non-zero status
//   timeout_vec_o                sticky per-action watchdog expiry
module nvme_cpl_tracker #(
    parameter int unsigned NUM_ACTIONS   = 16,
    parameter int unsigned TRACK_DEPTH   = 16,
    parameter int unsigned REQ_ID_BITS   = 8,
    parameter int unsigned INFO_BITS     = 2,
    parameter int unsigned TICK_SHIFT    = 10,
    parameter int unsigned TIMEOUT_TICKS = 1024,
    localparam int unsigned AID_BITS     = $clog2(NUM_ACTIONS)
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    output logic                   init_done_o,
    input  logic                   cpl_valid_i,
    input  logic                   cpl_admin_i,
    input  logic [AID_BITS-1:0]    cpl_action_id_i,
    input  logic [REQ_ID_BITS-1:0] cpl_req_id_i,
    input  logic [14:0]            cpl_status_i,
    input  logic [127:0]           cpl_data_i,
    input  logic                   issue_valid_i,
    input  logic [AID_BITS-1:0]    issue_action_id_i,
    output logic [NUM_ACTIONS-1:0] issue_full_o,
    input  logic                   pop_req_i,
    input  logic [AID_BITS-1:0]    pop_action_id_i,
    output logic                   pop_done_o,
    output logic                   pop_valid_o,
    output logic [INFO_BITS-1:0]   pop_data_o,
    output logic [NUM_ACTIONS-1:0] track_status_o,
    output logic                   overflow_o,
    input  logic                   err_clear_i,
    output logic                   err_valid_o,
    output logic [127:0]           err_data_o,
    output logic [15:0]            err_count_o,
    output logic [NUM_ACTIONS-1:0] timeout_vec_o
);

    localparam int unsigned SLOT_BITS = $clog2(TRACK_DEPTH);
    localparam int unsigned IDX_BITS  = AID_BITS + SLOT_BITS;
    localparam int unsigned ENTRIES   = NUM_ACTIONS * TRACK_DEPTH;
    localparam int unsigned OUT_BITS  = SLOT_BITS + 1;
    localparam logic [OUT_BITS-1:0] OutFull    = OUT_BITS'(TRACK_DEPTH);
    localparam logic [15:0]         TimeoutVal = 16'(TIMEOUT_TICKS);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e state_q, state_d;
    logic [IDX_BITS-1:0] init_idx_q, init_idx_d;
    logic run;

    // Memory-like store: no reset, cleared by the init sweep instead.
    logic [INFO_BITS-1:0] store_q [ENTRIES];

    logic [NUM_ACTIONS-1:0][SLOT_BITS-1:0] head_q, head_d;
    logic [NUM_ACTIONS-1:0][OUT_BITS-1:0]  outst_q, outst_d;
    logic [NUM_ACTIONS-1:0][15:0]          timer_q, timer_d;
    logic [NUM_ACTIONS-1:0]                ts_q, ts_d;
    logic [NUM_ACTIONS-1:0]                tov_q, tov_d;
    logic [TICK_SHIFT-1:0]                 tick_cnt_q;
    logic                                  tick;

    logic                 pop_done_q, pop_valid_q, overflow_q;
    logic [INFO_BITS-1:0] pop_data_q;
    logic                 err_valid_q, err_valid_d;
    logic [127:0]         err_data_q, err_data_d;
    logic [15:0]          err_count_q, err_count_d;

    logic [SLOT_BITS-1:0] cpl_slot;
    logic [INFO_BITS-1:0] cpl_entry, cpl_old, pop_entry;
    logic                 cpl_track, cpl_err, pop_ok;
    logic [NUM_ACTIONS-1:0] pop_hit, iss_hit, cpl_hit;
    logic unused_req_bits;

    assign unused_req_bits = ^cpl_req_id_i[REQ_ID_BITS-1:SLOT_BITS];

    assign run       = (state_q == StRun);
    assign cpl_slot  = cpl_req_id_i[SLOT_BITS-1:0];
    assign cpl_track = run && cpl_valid_i && !cpl_admin_i;
    assign cpl_err   = run && cpl_valid_i && (cpl_status_i != '0);
    assign cpl_old   = store_q[{cpl_action_id_i, cpl_slot}];
    assign pop_entry = store_q[{pop_action_id_i, head_q[pop_action_id_i]}];
    assign pop_ok    = run && pop_req_i && pop_entry[0];
    assign tick      = run && (&tick_cnt_q);

    assign pop_hit = pop_ok ? (NUM_ACTIONS'(1) << pop_action_id_i) : '0;
    assign cpl_hit = cpl_track ? (NUM_ACTIONS'(1) << cpl_action_id_i) : '0;
    assign iss_hit = (run && issue_valid_i) ? (NUM_ACTIONS'(1) << issue_action_id_i) : '0;

    // Entry layout: [0] valid, [1] error, [INFO_BITS-1:2] status LSBs.
    always_comb begin
        cpl_entry    = '0;
        cpl_entry[0] = 1'b1;
        cpl_entry[1] = (cpl_status_i != '0);
        for (int i = 2; i < INFO_BITS; i++) begin
            cpl_entry[i] = cpl_status_i[i-2];
        end
    end

    // Init sweep FSM.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        unique case (state_q)
            StInit: begin
                init_idx_d = init_idx_q + IDX_BITS'(1);
                if (init_idx_q == IDX_BITS'(ENTRIES - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: ;
            default: state_d = StInit;
        endcase
    end

    // Per-action head, outstanding, track status and watchdog.
    always_comb begin
        head_d  = head_q;
        outst_d = outst_q;
        ts_d    = ts_q;
        timer_d = timer_q;
        tov_d   = tov_q;
        if (run && err_clear_i) begin
            tov_d = '0;
        end
        for (int a = 0; a < NUM_ACTIONS; a++) begin
            if (pop_hit[a]) begin
                head_d[a] = head_q[a] + SLOT_BITS'(1);
                // A completion landing on the new head this cycle counts immediately.
                ts_d[a] = store_q[{AID_BITS'(a), head_d[a]}][0] |
                          (cpl_hit[a] && (cpl_slot == head_d[a]));
            end else if (cpl_hit[a] && (cpl_slot == head_q[a])) begin
                ts_d[a] = 1'b1;
            end

            if (iss_hit[a] && pop_hit[a]) begin
                outst_d[a] = outst_q[a];
            end else if (iss_hit[a] && !issue_full_o[a]) begin
                outst_d[a] = outst_q[a] + OUT_BITS'(1);
            end else if (pop_hit[a] && (outst_q[a] != '0)) begin
                outst_d[a] = outst_q[a] - OUT_BITS'(1);
            end

            if ((outst_q[a] == '0) || pop_hit[a] || ts_q[a]) begin
                timer_d[a] = '0;
            end else if (tick && (timer_q[a] != TimeoutVal)) begin
                timer_d[a] = timer_q[a] + 16'd1;
                // Flag only on the expiring tick so err_clear removes it for good.
                if (timer_d[a] == TimeoutVal) begin
                    tov_d[a] = 1'b1;
                end
            end
        end
    end

    // Error capture: a clear in the same cycle is applied before the new error.
    always_comb begin
        err_valid_d = err_valid_q;
        err_data_d  = err_data_q;
        err_count_d = err_count_q;
        if (run && err_clear_i) begin
            err_valid_d = 1'b0;
            err_data_d  = '0;
            err_count_d = '0;
        end
        if (cpl_err) begin
            if (err_count_d != 16'hFFFF) begin
                err_count_d = err_count_d + 16'd1;
            end
            if (!err_valid_d) begin
                err_valid_d = 1'b1;
                err_data_d  = cpl_data_i;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!run) begin
            store_q[init_idx_q] <= '0;
        end else begin
            if (pop_ok) begin
                store_q[{pop_action_id_i, head_q[pop_action_id_i]}] <= '0;
            end
            if (cpl_track) begin
                store_q[{cpl_action_id_i, cpl_slot}] <= cpl_entry;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= StInit;
            init_idx_q  <= '0;
            head_q      <= '0;
            outst_q     <= '0;
            timer_q     <= '0;
            ts_q        <= '0;
            tov_q       <= '0;
            tick_cnt_q  <= '0;
            pop_done_q  <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            overflow_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_data_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            head_q      <= head_d;
            outst_q     <= outst_d;
            timer_q     <= timer_d;
            ts_q        <= ts_d;
            tov_q       <= tov_d;
            if (run) begin
                tick_cnt_q <= tick_cnt_q + TICK_SHIFT'(1);
            end
            pop_done_q  <= run && pop_req_i;
            pop_valid_q <= pop_ok;
            pop_data_q  <= pop_ok ? pop_entry : '0;
            if (cpl_track && cpl_old[0]) begin
                overflow_q <= 1'b1;
            end
            err_valid_q <= err_valid_d;
            err_data_q  <= err_data_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        for (int a = 0; a < NUM_ACTIONS; a++) begin
            issue_full_o[a] = (outst_q[a] == OutFull);
        end
    end

    assign init_done_o    = run;
    assign pop_done_o     = pop_done_q;
    assign pop_valid_o    = pop_valid_q;
    assign pop_data_o     = pop_data_q;
    assign track_status_o = ts_q;
    assign overflow_o     = overflow_q;
    assign err_valid_o    = err_valid_q;
    assign err_data_o     = err_data_q;
    assign err_count_o    = err_count_q;
    assign timeout_vec_o  = tov_q;

endmodule
